// File: rtl/gpio_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : gpio_block_packer
// Purpose  : Packs strobed 16-bit GPIO words into SHA3-512 rate blocks with
//            SHA3 padding and hands them to the Keccak core via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_block_packer #(
  parameter int         RATE_WORDS  = 36,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                pi_data,
  input  logic                       pi_strobe,
  input  logic                       pi_last,
  input  logic                       pi_half,
  output logic                       pi_busy,
  input  logic                       clear,
  output logic [RATE_WORDS*16-1:0]   block_data,
  output logic                       block_valid,
  output logic                       block_last,
  input  logic                       block_ready,
  output logic                       msg_done,
  output logic                       err_overrun
);

  localparam int c_BITS  = RATE_WORDS * 16;
  localparam int c_BYTES = RATE_WORDS * 2;
  localparam int c_CW    = $clog2(RATE_WORDS + 1);
  localparam int c_PW    = $clog2(c_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PAD  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic [c_CW-1:0]        r_cnt;
  logic [c_PW-1:0]        r_pad_idx;
  logic                   r_pad_pending;
  logic [c_BITS-1:0]      r_buf;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_done;
  logic                   r_err;
  logic                   r_busy;

  logic                   w_edge;
  logic [c_CW-1:0]        w_cnt_next;
  logic [c_PW-1:0]        w_pad_idx_next;
  logic                   w_pad_full;
  logic [c_BITS-1:0]      w_padded;

  assign w_edge         = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_cnt_next     = r_cnt + 1'b1;
  // Pad byte follows the last data byte; a trailing half word gives one back.
  assign w_pad_idx_next = c_PW'(2 * int'(w_cnt_next) - int'(pi_last & pi_half));
  assign w_pad_full     = (int'(r_pad_idx) == c_BYTES);

  always_comb begin
    w_padded = r_buf;
    for (int b = 0; b < c_BYTES; b++) begin
      if (b == int'(r_pad_idx))
        w_padded[8*(c_BYTES-1-b) +: 8] = DOMAIN_BYTE;
      else if (b > int'(r_pad_idx))
        w_padded[8*(c_BYTES-1-b) +: 8] = 8'h00;
    end
    if (!w_pad_full)
      w_padded[7:0] = w_padded[7:0] | 8'h80;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_sync        <= '0;
      r_sync_d      <= 1'b0;
      r_cnt         <= '0;
      r_pad_idx     <= '0;
      r_pad_pending <= 1'b0;
      r_buf         <= '0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], pi_strobe};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      r_done   <= 1'b0;
      if (clear) begin
        r_state       <= S_IDLE;
        r_cnt         <= '0;
        r_pad_idx     <= '0;
        r_pad_pending <= 1'b0;
        r_buf         <= '0;
        r_valid       <= 1'b0;
        r_last        <= 1'b0;
        r_err         <= 1'b0;
        r_busy        <= 1'b0;
      end else begin
        if (w_edge && r_busy)
          r_err <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_buf <= '0;
            r_cnt <= '0;
            if (w_edge) begin
              r_buf     <= {pi_data, {(c_BITS-16){1'b0}}};
              r_cnt     <= w_cnt_next;
              r_pad_idx <= w_pad_idx_next;
              if (pi_last) begin
                r_state <= S_PAD;
                r_busy  <= 1'b1;
              end else begin
                r_state <= S_FILL;
              end
            end
          end
          S_FILL: begin
            if (w_edge) begin
              for (int k = 0; k < RATE_WORDS; k++)
                if (r_cnt == c_CW'(k))
                  r_buf[16*(RATE_WORDS-1-k) +: 16] <= pi_data;
              r_cnt     <= w_cnt_next;
              r_pad_idx <= w_pad_idx_next;
              if (pi_last) begin
                r_state <= S_PAD;
                r_busy  <= 1'b1;
              end else if (int'(r_cnt) == RATE_WORDS - 1) begin
                r_state <= S_HOLD;
                r_valid <= 1'b1;
                r_last  <= 1'b0;
                r_busy  <= 1'b1;
              end
            end
          end
          S_PAD: begin
            // An exactly full block goes out unpadded; padding follows alone.
            r_buf         <= w_padded;
            r_valid       <= 1'b1;
            r_state       <= S_HOLD;
            r_last        <= ~w_pad_full;
            r_pad_pending <= w_pad_full;
          end
          S_HOLD: begin
            if (block_ready) begin
              r_valid <= 1'b0;
              r_buf   <= '0;
              r_cnt   <= '0;
              r_last  <= 1'b0;
              if (r_last) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else if (r_pad_pending) begin
                r_state       <= S_PAD;
                r_pad_idx     <= '0;
                r_pad_pending <= 1'b0;
              end else begin
                r_state <= S_FILL;
                r_busy  <= 1'b0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign pi_busy     = r_busy;
  assign block_data  = r_buf;
  assign block_valid = r_valid;
  assign block_last  = r_last;
  assign msg_done    = r_done;
  assign err_overrun = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gpio_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_block_packer
// Purpose  : Directed self-checking bench for gpio_block_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_block_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  pi_data;
  logic         pi_strobe;
  logic         pi_last;
  logic         pi_half;
  logic         pi_busy;
  logic         clear;
  logic [575:0] block_data;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;
  logic         msg_done;
  logic         err_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  gpio_block_packer #(
    .RATE_WORDS (36),
    .SYNC_STAGES(2),
    .DOMAIN_BYTE(8'h06)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pi_data    (pi_data),
    .pi_strobe  (pi_strobe),
    .pi_last    (pi_last),
    .pi_half    (pi_half),
    .pi_busy    (pi_busy),
    .clear      (clear),
    .block_data (block_data),
    .block_valid(block_valid),
    .block_last (block_last),
    .block_ready(block_ready),
    .msg_done   (msg_done),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [15:0] d, input logic l, input logic h);
    @(negedge clk);
    pi_data = d; pi_last = l; pi_half = h;
    @(negedge clk);
    pi_strobe = 1'b1;
    repeat (6) @(negedge clk);
    pi_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int i = 0;
    while (block_valid !== 1'b1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (block_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid_timeout: got %b want 1", name, block_valid);
    end
  endtask

  task automatic accept(input logic exp_done, input string name);
    @(negedge clk);
    block_ready = 1'b1;
    @(posedge clk);
    #1 block_ready = 1'b0;
    n_cmp++;
    if (msg_done !== exp_done) begin
      n_fail++;
      $display("FAIL %s msg_done: got %b want %b", name, msg_done, exp_done);
    end
    n_cmp++;
    if (block_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s valid_drop: got %b want 0", name, block_valid);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (msg_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s msg_done_pulse: got %b want 0", name, msg_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; pi_data = '0; pi_strobe = 1'b0; pi_last = 1'b0;
    pi_half = 1'b0; clear = 1'b0; block_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({block_data, block_valid, block_last, msg_done, err_overrun, pi_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%b e=%b b=%b data=%h want all 0",
               block_valid, block_last, msg_done, err_overrun, pi_busy, block_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_word();
    logic [575:0] exp = '0;
    exp[575 -: 16] = 16'h6162;
    exp[559 -: 16] = 16'h0600;
    exp[15:0]      = 16'h0080;
    send_word(16'h6162, 1'b1, 1'b0);
    wait_valid("one_word");
    n_cmp++;
    if (block_data !== exp) begin
      n_fail++;
      $display("FAIL one_word data: got %h want %h", block_data, exp);
    end
    n_cmp++;
    if (block_last !== 1'b1 || pi_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL one_word last_busy: got last=%b busy=%b want 1 1", block_last, pi_busy);
    end
    accept(1'b1, "one_word");
  endtask

  task automatic test_half_word();
    logic [575:0] exp = '0;
    exp[575 -: 16] = 16'h6106;
    exp[15:0]      = 16'h0080;
    send_word(16'h61FF, 1'b1, 1'b1);
    wait_valid("half_word");
    n_cmp++;
    if (block_data !== exp || block_last !== 1'b1) begin
      n_fail++;
      $display("FAIL half_word data: got last=%b %h want last=1 %h", block_last, block_data, exp);
    end
    accept(1'b1, "half_word");
  endtask

  task automatic test_pad_at_71();
    logic [575:0] exp = '0;
    for (int k = 0; k < 35; k++) begin
      exp[16*(35-k) +: 16] = 16'h0100 + 16'(k);
      send_word(16'h0100 + 16'(k), 1'b0, 1'b0);
    end
    n_cmp++;
    if (block_valid !== 1'b0 || pi_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pad71 premature: got valid=%b busy=%b want 0 0", block_valid, pi_busy);
    end
    exp[15:0] = 16'hAB86;
    send_word(16'hAB00, 1'b1, 1'b1);
    wait_valid("pad71");
    n_cmp++;
    if (block_data !== exp || block_last !== 1'b1) begin
      n_fail++;
      $display("FAIL pad71 data: got last=%b %h want last=1 %h", block_last, block_data, exp);
    end
    accept(1'b1, "pad71");
  endtask

  task automatic test_full_block();
    logic [575:0] exp = '0;
    for (int k = 0; k < 36; k++) begin
      exp[16*(35-k) +: 16] = 16'hC000 + 16'(k);
      send_word(16'hC000 + 16'(k), (k == 35), 1'b0);
    end
    wait_valid("full_blk1");
    n_cmp++;
    if (block_data !== exp || block_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_blk1 data: got last=%b %h want last=0 %h", block_last, block_data, exp);
    end
    accept(1'b0, "full_blk1");
    exp = '0;
    exp[575 -: 16] = 16'h0600;
    exp[15:0]      = 16'h0080;
    wait_valid("full_blk2");
    n_cmp++;
    if (block_data !== exp || block_last !== 1'b1) begin
      n_fail++;
      $display("FAIL full_blk2 data: got last=%b %h want last=1 %h", block_last, block_data, exp);
    end
    accept(1'b1, "full_blk2");
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL full_block err: got %b want 0", err_overrun);
    end
  endtask

  task automatic test_overrun();
    logic [575:0] exp = '0;
    exp[575 -: 16] = 16'h7071;
    exp[559 -: 16] = 16'h0600;
    exp[15:0]      = 16'h0080;
    send_word(16'h7071, 1'b1, 1'b0);
    wait_valid("overrun");
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b1, 1'b0);
    n_cmp++;
    if (block_data !== exp || block_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun data: got valid=%b %h want valid=1 %h", block_valid, block_data, exp);
    end
    n_cmp++;
    if (pi_busy !== 1'b1 || err_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun flags: got busy=%b err=%b want 1 1", pi_busy, err_overrun);
    end
    accept(1'b1, "overrun");
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun sticky: got %b want 1", err_overrun);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun clear: got %b want 0", err_overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [575:0] exp = '0;
    for (int k = 0; k < 10; k++) begin
      exp[16*(35-k) +: 16] = 16'h5A00 + 16'(k);
      send_word(16'h5A00 + 16'(k), 1'b0, 1'b0);
    end
    n_cmp++;
    if (block_data !== exp) begin
      n_fail++;
      $display("FAIL reset_mid partial: got %h want %h", block_data, exp);
    end
    @(negedge clk);
    pi_data = 16'hDEAD;
    @(negedge clk);
    pi_strobe = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({block_data, block_valid, block_last, msg_done, err_overrun, pi_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got v=%b l=%b b=%b data=%h want all 0",
               block_valid, block_last, pi_busy, block_data);
    end
    @(negedge clk);
    pi_strobe = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp = '0;
    exp[575 -: 16] = 16'h1234;
    exp[559 -: 16] = 16'h0600;
    exp[15:0]      = 16'h0080;
    send_word(16'h1234, 1'b1, 1'b0);
    wait_valid("reset_mid_new");
    n_cmp++;
    if (block_data !== exp || block_last !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid new: got last=%b %h want last=1 %h", block_last, block_data, exp);
    end
    accept(1'b1, "reset_mid_new");
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_half_word();
    test_pad_at_71();
    test_full_block();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpio_block_packer.md
Name: gpio_block_packer

Overview:
- Upstream neighbour of the 512-bit-to-GPIO output converter, on the input side of the SHA3-512 datapath.
- Receives 16-bit message words from the Raspberry Pi over GPIO, using an asynchronous Pi strobe.
- Packs the words into 576-bit SHA3-512 rate blocks and applies SHA3 padding.
- Presents each block to the Keccak core through a valid/ready handshake.

Parameters:
RATE_WORDS, 36, 16-bit words per rate block (576 bits / 16).
SYNC_STAGES, 2, flip-flops in the pi_strobe synchronizer (minimum 2).
DOMAIN_BYTE, 8'h06, SHA3 domain/pad-start byte.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is used synchronously.
pi_data  input  16  message word; bits [15:8] are the earlier byte.
pi_strobe  input  1  asynchronous Pi strobe; a rising edge means "word valid".
pi_last  input  1  sampled with the word; 1 = final word of the message.
pi_half  input  1  sampled with the word; valid only with pi_last; 1 = only [15:8] carries data.
pi_busy  output  1  1 = the Pi must not strobe.
clear  input  1  synchronous abort: discard the message and return to IDLE.
block_data  output  576  word k occupies [575-16k : 560-16k].
block_valid  output  1  block_data is stable and complete.
block_last  output  1  qualifies block_valid; 1 = final block of the message.
block_ready  input  1  the core accepts the block in the cycle where block_valid and block_ready are both 1.
msg_done  output  1  one-cycle pulse when the final block is accepted.
err_overrun  output  1  sticky flag; set when a strobe edge arrives while pi_busy=1.

Behaviour:
- Reset values: block_data=0, block_valid=0, block_last=0, msg_done=0, err_overrun=0, pi_busy=0, word_cnt=0, state=IDLE, synchronizer flops=0.
- Strobe path:
  - pi_strobe passes through SYNC_STAGES flops, then a rising-edge detector.
  - pi_data, pi_last and pi_half are captured in the edge-detect cycle, SYNC_STAGES+1 clocks after the pin rises.
  - The Pi holds the data pins stable from ≥1 clk before until ≥4 clk after the strobe edge.
- States: IDLE, FILL, PAD, HOLD.
- IDLE: word_cnt=0 and the buffer is zeroed. A strobe edge writes word 0, then:
  - pi_last=0 -> FILL.
  - pi_last=1 -> PAD.
- FILL: each edge writes word[word_cnt] and increments word_cnt. Then:
  - pi_last=1 -> PAD.
  - else if word_cnt was RATE_WORDS-1 -> HOLD with block_last=0.
- PAD takes exactly one cycle and fills the rest of the block:
  - The pad byte index p is the byte following the last data byte: p = 2*(words written); subtract 1 if pi_half=1.
  - Byte p = DOMAIN_BYTE, all later bytes = 0, then byte 71 is OR'd with 8'h80.
  - If p==71, byte 71 = 8'h86.
  - If p==72 (block exactly full), emit this block with block_last=0 and set pad_pending. The following block is byte0=0x06, bytes 1-70=0, byte71=0x80, block_last=1.
  - Otherwise -> HOLD with block_last=1.
- HOLD: block_valid=1 and block_data is frozen. On block_ready:
  - block_valid drops the next cycle and the buffer is zeroed.
  - block_last=1 -> pulse msg_done, go to IDLE.
  - pad_pending -> go to PAD with word_cnt=0, clear pad_pending.
  - else -> FILL with word_cnt=0.
- pi_busy = 1 in PAD and HOLD, and for the cycle of a FILL->HOLD transition.
- A strobe edge while pi_busy=1 is ignored and sets err_overrun. err_overrun clears only on reset or clear.
- clear: takes priority over all state activity. Next cycle: IDLE, buffer and counters zeroed, block_valid=0, err_overrun=0, pad_pending=0. An edge in the same cycle as clear is dropped.
- Simultaneous events:
  - block_ready while block_valid=0 is ignored.
  - A strobe edge arriving in the same cycle as a HOLD exit is dropped and counted as an overrun (pi_busy was high).
- Reset mid-operation: asynchronous return to the reset values; a partial block is discarded.
- pi_half with pi_last=0 is ignored (treated as a full word).

Test Plan:
- One word 0x6162, last=1 -> one block: word0=0x6162, word1=0x0600, words2-34=0, word35=0x0080, block_last=1. msg_done pulses one cycle after ready.
- One half word 0x61xx, last=1, half=1 -> word0=0x6106, word35=0x0080, all other words 0.
- 35 full words, then 0xAB00 with last=1, half=1 -> word35=0xAB86, single block, block_last=1.
- 36 full words with last on the 36th -> block 1 holds the data with block_last=0. Block 2: word0=0x0600, word35=0x0080, block_last=1. msg_done follows block 2 only.
- Hold block_ready=0 in HOLD and strobe twice -> data unchanged, pi_busy=1, err_overrun=1. Raise ready -> accepted; clear -> err_overrun=0.
- Strobe 10 words, pull reset low mid-strobe -> all outputs 0 immediately. A new 1-word message after release packs from word0.
